// File: rtl/apb_pkg.sv
// Shared definitions for the APB3 master bridge.
// Holds the bus width and timeout defaults and the FSM state encoding.
// The states are plain localparam constants so that older tools and
// waveform scripts that compare raw 2-bit values keep working.
package apb_pkg;

    localparam int unsigned APB_DATA_WIDTH     = 32;
    localparam int unsigned APB_ADDRESS_WIDTH  = 32;
    localparam int unsigned APB_TIMEOUT_CYCLES = 256;
    localparam int unsigned APB_TIMEOUT_WIDTH  = 16;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 2'd0;
    localparam apb_state_t ST_SETUP  = 2'd1;
    localparam apb_state_t ST_ACCESS = 2'd2;
    localparam apb_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of the bridge's requester-side and APB-side signals.
//   cmd_*   : command channel, requester -> bridge (valid/ready)
//   rsp_*   : response channel, bridge -> requester (valid/ready)
//   P*      : APB3 bus between bridge (initiator) and peripheral slaves
// Modports:
//   master : the bridge's view (drives cmd_ready, rsp_*, PSEL..PWDATA)
//   slave  : the environment's view (requester plus peripheral side)
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = APB_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = APB_ADDRESS_WIDTH
);

    // Command channel
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;

    // Response channel
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;
    logic                     rsp_timeout;

    // APB3 bus
    logic                     PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [ADDRESS_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0]    PWDATA;
    logic [DATA_WIDTH-1:0]    PRDATA;
    logic                     PREADY;
    logic                     PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge.sv
// APB3 initiator bridge.
// Takes one read/write command at a time from a local requester, runs the
// APB SETUP and ACCESS phases (honouring PREADY wait states) and returns
// the result on a held response handshake. A wait-state counter aborts a
// transfer whose slave keeps PREADY low for TIMEOUT_CYCLES ACCESS cycles.
// Ports:
//   PCLK   : bus clock, single clock of the block
//   PRESET : synchronous active-high reset
//   bus    : apb_master_bridge_if.master (cmd_*, rsp_*, APB signals)
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH  = APB_ADDRESS_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_WIDTH  = APB_TIMEOUT_WIDTH
) (
    input logic                 PCLK,
    input logic                 PRESET,
    apb_master_bridge_if.master bus
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST =
        TIMEOUT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_ONE = TIMEOUT_WIDTH'(1);

    apb_state_t               state_q,   state_d;
    logic                     psel_q,    psel_d;
    logic                     penable_q, penable_d;
    logic                     pwrite_q,  pwrite_d;
    logic [ADDRESS_WIDTH-1:0] paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0]    pwdata_q,  pwdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q,   rdata_d;
    logic                     err_q,     err_d;
    logic                     timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] wait_q,    wait_d;

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        wait_d    = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    // Reads never expose stale requester data on PWDATA.
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (bus.PREADY) begin
                    rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    err_d     = bus.PSLVERR;
                    timeout_d = 1'b0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    wait_d    = '0;
                    state_d   = ST_RESP;
                end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    wait_d    = '0;
                    state_d   = ST_RESP;
                end else if (wait_q != '1) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    wait_d = wait_q + WAIT_ONE;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
        end
    end

    // Handshake flags follow the state directly, so cmd_ready and rsp_valid
    // can never both be high and no command is taken during RESP.
    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = timeout_q;

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge (TIMEOUT_CYCLES = 8).
module tb_apb_master_bridge;

    logic PCLK;
    logic PRESET;

    int n_checks;
    int n_errors;
    int psel_cycles;
    int access_cycles;
    int rsp_seen;

    apb_master_bridge_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    apb_master_bridge #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_WIDTH (16)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        PRESET    = 1'b1;
        bus.cmd_valid = 1'b1;   // must be ignored while in reset
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'hFFFF_FFF0;
        bus.cmd_wdata = 32'h1234_5678;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = 32'h0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        check("reset_psel", bus.PSEL, 0);
        check("reset_penable", bus.PENABLE, 0);
        check("reset_pwrite", bus.PWRITE, 0);
        check("reset_paddr", bus.PADDR, 0);
        check("reset_pwdata", bus.PWDATA, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_rsp_timeout", bus.rsp_timeout, 0);
        check("reset_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
        PRESET = 1'b0;
        step();
        check("idle_psel", bus.PSEL, 0);

        // ---------------- write, zero wait ----------------
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h4;
        bus.cmd_wdata = 32'h0000_00A5;
        bus.PREADY    = 1'b1;
        step();                             // accept edge N -> SETUP
        bus.cmd_valid = 1'b0;
        check("wr_setup_psel", bus.PSEL, 1);
        check("wr_setup_penable", bus.PENABLE, 0);
        check("wr_setup_paddr", bus.PADDR, 32'h4);
        check("wr_setup_pwdata", bus.PWDATA, 32'hA5);
        check("wr_setup_pwrite", bus.PWRITE, 1);
        check("wr_setup_cmd_ready", bus.cmd_ready, 0);
        step();                             // N+1 -> ACCESS
        check("wr_access_psel", bus.PSEL, 1);
        check("wr_access_penable", bus.PENABLE, 1);
        check("wr_access_paddr", bus.PADDR, 32'h4);
        check("wr_access_rsp_valid", bus.rsp_valid, 0);
        step();                             // N+2 -> RESP
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rsp_psel", bus.PSEL, 0);
        check("wr_rsp_penable", bus.PENABLE, 0);
        check("wr_rsp_err", bus.rsp_err, 0);
        check("wr_rsp_rdata", bus.rsp_rdata, 0);
        rsp_handshake();
        check("wr_done_rsp_valid", bus.rsp_valid, 0);
        check("wr_done_cmd_ready", bus.cmd_ready, 1);

        // ---------------- read with 3 wait states ----------------
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'hBAD0_BAD0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h8;
        bus.cmd_wdata = 32'hFFFF_FFFF;
        step();
        bus.cmd_valid = 1'b0;
        check("rd_setup_pwdata", bus.PWDATA, 0);
        check("rd_setup_pwrite", bus.PWRITE, 0);
        psel_cycles = 0;
        // i=0 SETUP, i=1..3 ACCESS stalled, i=4 ACCESS with PREADY high
        for (int i = 0; i < 12 && !bus.rsp_valid; i++) begin
            if (bus.PSEL) psel_cycles++;
            if (i == 4) begin
                bus.PREADY = 1'b1;
                bus.PRDATA = 32'h0000_005A;
            end
            step();
        end
        check("rd_psel_cycles", psel_cycles, 5);
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'h5A);
        check("rd_rsp_err", bus.rsp_err, 0);
        check("rd_rsp_timeout", bus.rsp_timeout, 0);
        rsp_handshake();

        // ---------------- slave error ----------------
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b1;
        bus.PRDATA    = 32'h0000_1234;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'hC;
        step();
        bus.cmd_valid = 1'b0;
        check("err_setup_paddr", bus.PADDR, 32'hC);
        step();
        step();
        bus.PSLVERR = 1'b0;
        check("err_rsp_valid", bus.rsp_valid, 1);
        check("err_rsp_err", bus.rsp_err, 1);
        check("err_rsp_timeout", bus.rsp_timeout, 0);
        check("err_rsp_rdata", bus.rsp_rdata, 32'h1234);
        rsp_handshake();

        // ---------------- timeout ----------------
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'hFFFF_FFFF;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h10;
        step();                             // SETUP
        bus.cmd_valid = 1'b0;
        step();                             // first ACCESS cycle
        access_cycles = 0;
        for (int i = 0; i < 20 && bus.PSEL; i++) begin
            if (bus.PENABLE) access_cycles++;
            step();
        end
        check("to_access_cycles", access_cycles, 8);
        check("to_rsp_valid", bus.rsp_valid, 1);
        check("to_rsp_err", bus.rsp_err, 1);
        check("to_rsp_timeout", bus.rsp_timeout, 1);
        check("to_rsp_rdata", bus.rsp_rdata, 0);
        check("to_penable", bus.PENABLE, 0);
        rsp_handshake();

        // ---------------- backpressure and back-to-back ----------------
        bus.PREADY    = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h14;
        bus.cmd_wdata = 32'h1122_3344;
        step();                             // accept first
        bus.cmd_write = 1'b0;               // second command, held valid
        bus.cmd_addr  = 32'h18;
        bus.cmd_wdata = 32'h0;
        step();
        step();                             // now in RESP
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_rdata", bus.rsp_rdata, 0);
            check("bp_rsp_err", bus.rsp_err, 0);
            check("bp_rsp_timeout", bus.rsp_timeout, 0);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_psel", bus.PSEL, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();                             // response handshake -> IDLE
        bus.rsp_ready = 1'b0;
        check("b2b_idle_cmd_ready", bus.cmd_ready, 1);
        check("b2b_idle_psel", bus.PSEL, 0);
        check("b2b_idle_rsp_valid", bus.rsp_valid, 0);
        bus.PRDATA = 32'hCAFE_F00D;
        step();                             // second command accepted
        bus.cmd_valid = 1'b0;
        check("b2b_setup_psel", bus.PSEL, 1);
        check("b2b_setup_paddr", bus.PADDR, 32'h18);
        check("b2b_setup_pwrite", bus.PWRITE, 0);
        step();
        step();
        check("b2b_rsp_valid", bus.rsp_valid, 1);
        check("b2b_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        rsp_handshake();

        // ---------------- reset mid-ACCESS ----------------
        bus.PREADY    = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h1C;
        step();                             // SETUP
        bus.cmd_valid = 1'b0;
        step();                             // ACCESS
        step();                             // ACCESS, still waiting
        check("rst_pre_penable", bus.PENABLE, 1);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        check("rst_psel", bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_paddr", bus.PADDR, 0);
        bus.PREADY = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.rsp_valid || bus.PSEL) rsp_seen++;
        end
        check("rst_no_response", rsp_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 initiator that drives the peripheral bus hosting the UART/GPIO slaves.
- Accepts single read/write commands from a local requester (CPU-side glue or test sequencer) over a valid/ready interface.
- Runs the APB SETUP/ACCESS phases and honours PREADY wait states.
- Returns read data and error status over a held response handshake; a programmable timeout aborts transfers to a stalled slave.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
- ADDRESS_WIDTH, 32, width of PADDR/cmd_addr.
- TIMEOUT_CYCLES, 256, consecutive PREADY-low ACCESS cycles before abort; 0 disables the timeout.
- TIMEOUT_WIDTH, 16, width of the wait-state counter; TIMEOUT_CYCLES must be < 2^TIMEOUT_WIDTH.

Ports:
- PCLK  in  1  bus clock; the single clock of the block.
- PRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDRESS_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDRESS_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is PRESET, synchronous and active-high.
- Reset values: state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0. rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0. Wait counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1 here only. Commands presented while PRESET is high are ignored.
  - On cmd_valid & cmd_ready at edge N: register PADDR, PWDATA, PWRITE from cmd_*; set PSEL=1, PENABLE=0; go to SETUP.
  - PWDATA is registered as 0 for reads.
- SETUP: exactly one cycle. At the next edge, set PENABLE=1 and go to ACCESS. Address, data and direction stay stable from SETUP until ACCESS completes.
- ACCESS, PREADY=1 at an edge:
  - Capture rsp_rdata = PRDATA for reads, 0 for writes.
  - rsp_err = PSLVERR, rsp_timeout = 0.
  - Drive PSEL=0, PENABLE=0; clear the counter; go to RESP.
  - PSLVERR is sampled only in this cycle.
- ACCESS, PREADY=0: the counter increments.
- Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, then at that edge:
  - Drive PSEL=0, PENABLE=0.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
  - Net effect: at most TIMEOUT_CYCLES ACCESS cycles.
- RESP:
  - rsp_valid=1, with rsp_* held stable until rsp_valid & rsp_ready at an edge.
  - That edge returns to IDLE and clears rsp_valid. rsp_rdata/rsp_err/rsp_timeout keep their last values.
  - No new command is accepted in the same cycle.
- Latency: zero-wait transfer gives accept edge N, SETUP N+1, ACCESS N+2, rsp_valid in N+3. Minimum throughput is one transfer per 4 cycles.
- Bus idle: PSEL never asserts outside SETUP/ACCESS. PENABLE is never 1 without PSEL.
- Reset mid-transfer: at any state, PRESET at an edge forces all reset values. The in-flight transfer is dropped with no response.
- Width rules: straight pass-through, no address alignment or decoding; slaves decode PADDR[3:0] themselves. The counter saturates at its terminal value and never wraps.

Decomposition:
- Shared package apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default DATA_WIDTH/ADDRESS_WIDTH constants, timeout default.
- No sub-module; FSM and wait counter live in one module. If reuse is needed, the counter is extracted as apb_wait_timer.

Test Plan:
- Write, zero-wait: cmd write addr=0x4 wdata=0x000000A5, PREADY=1 -> SETUP and ACCESS one cycle each, PADDR=0x4, PWDATA=0xA5, PWRITE=1; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with wait states: read addr=0x8, slave holds PREADY=0 for 3 ACCESS cycles, then PRDATA=0x5A, PREADY=1 -> rsp_rdata=0x5A, rsp_err=0; PSEL high for exactly 5 cycles.
- Slave error: read addr=0xC, PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, PREADY stuck 0 -> PSEL drops after exactly 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Response backpressure and back-to-back: rsp_ready low for 4 cycles with cmd_valid held -> rsp_* stable, cmd_ready=0, PSEL=0 throughout; second command accepted the cycle after the rsp handshake.
- Reset mid-ACCESS: PRESET=1 for one edge while PREADY=0 -> next cycle PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1; no response is ever emitted for the dropped transfer.
